bridge_state_monitor: RTL and testbench

- Decoder and checker for the four gate-drive signals of the three-level full bridge, taken after dead-time insertion.
- Decodes the instantaneous bridge output level (+1/0/-1) and measures per-leg dead time and modulation period.
- Detects shoot-through, short dead time and illegal level jumps.
- Drives a sticky fault that the top level ANDs into the gate outputs. It sits beside the dead_time instances on clk_100M.

---
 rtl/bridge_pkg.sv | 37 +++
 rtl/bridge_state_monitor_leg_deadtime_meter.sv | 86 ++++++++
 rtl/bridge_state_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_bridge_state_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared encodings for the full-bridge gate-state monitor: output levels,
// fault causes, monitor FSM states and gate bit positions.
package bridge_pkg;

    // Signed two-bit bridge output level
    localparam logic [1:0] LVL_POS  = 2'b01;
    localparam logic [1:0] LVL_ZERO = 2'b00;
    localparam logic [1:0] LVL_NEG  = 2'b11;

    // Gate bit positions inside the four-bit gate bus
    localparam int Q1_IDX = 0;  // leg A high switch
    localparam int Q2_IDX = 1;  // leg B high switch
    localparam int Q3_IDX = 2;  // leg A low switch
    localparam int Q4_IDX = 3;  // leg B low switch

    // First-cause fault code
    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_SHOOT_A  = 3'd1,
        FLT_SHOOT_B  = 3'd2,
        FLT_SHORT_DT = 3'd3,
        FLT_JUMP     = 3'd4
    } fault_code_t;

    // Monitor FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // True when two levels are a full +1 <-> -1 swing apart
    function automatic logic is_jump(input logic [1:0] a, input logic [1:0] b);
        return ((a == LVL_POS) && (b == LVL_NEG)) || ((a == LVL_NEG) && (b == LVL_POS));
    endfunction

endpackage

// File: rtl/bridge_state_monitor_leg_deadtime_meter.sv
// One bridge leg: classifies the high/low gate pair, measures each dead
// interval and flags shoot-through and too-short dead time while running.
import bridge_pkg::*;

module leg_deadtime_meter #(
    parameter int              DT_W     = 10,
    parameter logic [DT_W-1:0] P_MIN_DT = 10'd20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            high,
    input  logic            low,
    output logic            dead,
    output logic            shoot,
    output logic [DT_W-1:0] dt,
    output logic            dt_valid,
    output logic            dt_short
);

    logic            dead_c;
    logic            shoot_c;
    logic            driven_c;

    logic [DT_W-1:0] cnt_reg,      cnt_next;
    logic            first_reg,    first_next;
    logic [DT_W-1:0] dt_reg,       dt_next;
    logic            dt_valid_reg, dt_valid_next;
    logic            dt_short_reg, dt_short_next;
    logic            shoot_reg,    shoot_next;

    assign dead_c   = ~high & ~low;
    assign shoot_c  =  high &  low;
    assign driven_c =  high ^  low;

    // Dead-interval counting, latching on the dead -> driven edge
    always_comb begin
        cnt_next      = cnt_reg;
        first_next    = first_reg;
        dt_next       = dt_reg;
        dt_valid_next = 1'b0;
        dt_short_next = 1'b0;
        shoot_next    = run & shoot_c;
        if (!run) begin
            // Outside RUN the meter is held cleared; the next interval is "first"
            cnt_next   = '0;
            first_next = 1'b1;
        end else if (dead_c) begin
            if (cnt_reg != '1) begin
                cnt_next = cnt_reg + DT_W'(1);
            end
        end else if (driven_c && (cnt_reg != '0)) begin
            dt_next       = cnt_reg;
            dt_valid_next = 1'b1;
            dt_short_next = ~first_reg & (cnt_reg < P_MIN_DT);
            cnt_next      = '0;
            first_next    = 1'b0;
        end
    end

    // Meter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            first_reg    <= 1'b1;
            dt_reg       <= '0;
            dt_valid_reg <= 1'b0;
            dt_short_reg <= 1'b0;
            shoot_reg    <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            first_reg    <= first_next;
            dt_reg       <= dt_next;
            dt_valid_reg <= dt_valid_next;
            dt_short_reg <= dt_short_next;
            shoot_reg    <= shoot_next;
        end
    end

    assign dead     = dead_c;
    assign shoot    = shoot_reg;
    assign dt       = dt_reg;
    assign dt_valid = dt_valid_reg;
    assign dt_short = dt_short_reg;

endmodule

// File: rtl/bridge_state_monitor.sv
// Full-bridge gate-state monitor: decodes the output level, measures dead
// time and modulation period, and latches the first fault cause.
import bridge_pkg::*;

module bridge_state_monitor #(
    parameter int              DT_W     = 10,
    parameter logic [DT_W-1:0] P_MIN_DT = 10'd20,
    parameter int              PER_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [3:0]       i_Q,
    output logic [1:0]       o_level,
    output logic             o_level_valid,
    output logic [DT_W-1:0]  o_dt_a,
    output logic [DT_W-1:0]  o_dt_b,
    output logic [1:0]       o_dt_valid,
    output logic [PER_W-1:0] o_period,
    output logic             o_period_valid,
    output logic             o_fault,
    output logic [2:0]       o_fault_code,
    output logic             o_gate_ok
);

    logic [3:0]       q_reg;
    state_t           state_reg, state_next;
    logic             run;

    logic [1:0]       leg_dead;
    logic [1:0]       leg_shoot;
    logic [1:0]       leg_both_on;
    logic [1:0]       leg_high;
    logic [DT_W-1:0]  leg_dt [2];
    logic [1:0]       leg_dt_valid;
    logic [1:0]       leg_dt_short;

    logic             lvl_valid_c;
    logic [1:0]       lvl_c;
    logic [1:0]       level_reg;
    logic             level_valid_reg;
    logic [1:0]       last_lvl_reg,   last_lvl_next;
    logic             jump_reg;
    logic             pos_entry_c;

    logic [PER_W-1:0] per_cnt_reg,    per_cnt_next;
    logic             per_first_reg,  per_first_next;
    logic [PER_W-1:0] period_reg,     period_next;
    logic             per_valid_reg,  per_valid_next;

    fault_code_t      cause;
    logic             fault_reg,      fault_next;
    fault_code_t      code_reg,       code_next;
    logic             gate_ok_reg;

    assign run = (state_reg == ST_RUN);

    // Single input register; every decision below is taken on q_reg
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= i_Q;
        end
    end

    // Leg A pairs Q1/Q3, leg B pairs Q2/Q4
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_leg
            localparam int HI_IDX = (gi == 0) ? Q1_IDX : Q2_IDX;
            localparam int LO_IDX = (gi == 0) ? Q3_IDX : Q4_IDX;

            assign leg_high[gi]    = q_reg[HI_IDX] & ~q_reg[LO_IDX];
            assign leg_both_on[gi] = q_reg[HI_IDX] &  q_reg[LO_IDX];

            leg_deadtime_meter #(
                .DT_W     (DT_W),
                .P_MIN_DT (P_MIN_DT)
            ) u_meter (
                .clk      (i_clk),
                .rst_n    (i_reset),
                .run      (run),
                .high     (q_reg[HI_IDX]),
                .low      (q_reg[LO_IDX]),
                .dead     (leg_dead[gi]),
                .shoot    (leg_shoot[gi]),
                .dt       (leg_dt[gi]),
                .dt_valid (leg_dt_valid[gi]),
                .dt_short (leg_dt_short[gi])
            );
        end
    endgenerate

    // Level is defined only when neither leg is dead or shooting through
    always_comb begin
        lvl_valid_c = ~(|leg_dead) & ~(|leg_both_on);
        if (leg_high[0] & ~leg_high[1]) begin
            lvl_c = LVL_POS;
        end else if (~leg_high[0] & leg_high[1]) begin
            lvl_c = LVL_NEG;
        end else begin
            lvl_c = LVL_ZERO;
        end
        last_lvl_next = last_lvl_reg;
        if (!run) begin
            last_lvl_next = LVL_ZERO;
        end else if (lvl_valid_c) begin
            last_lvl_next = lvl_c;
        end
        pos_entry_c = run & lvl_valid_c & (lvl_c == LVL_POS) & (last_lvl_reg != LVL_POS);
    end

    // Level output (holds through dead bands) and jump detection
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            level_reg       <= LVL_ZERO;
            level_valid_reg <= 1'b0;
            last_lvl_reg    <= LVL_ZERO;
            jump_reg        <= 1'b0;
        end else begin
            if (lvl_valid_c) begin
                level_reg <= lvl_c;
            end
            level_valid_reg <= lvl_valid_c;
            last_lvl_reg    <= last_lvl_next;
            jump_reg        <= run & lvl_valid_c & is_jump(lvl_c, last_lvl_reg);
        end
    end

    // Period between +1 entries; the first entry after RUN only arms the count
    always_comb begin
        per_cnt_next   = per_cnt_reg;
        per_first_next = per_first_reg;
        period_next    = period_reg;
        per_valid_next = 1'b0;
        if (!run) begin
            per_cnt_next   = '0;
            per_first_next = 1'b1;
        end else if (pos_entry_c) begin
            per_cnt_next   = PER_W'(1);
            per_first_next = 1'b0;
            if (!per_first_reg) begin
                period_next    = per_cnt_reg;
                per_valid_next = 1'b1;
            end
        end else if (per_cnt_reg != '1) begin
            per_cnt_next = per_cnt_reg + PER_W'(1);
        end
    end

    // Period registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            per_cnt_reg   <= '0;
            per_first_reg <= 1'b1;
            period_reg    <= '0;
            per_valid_reg <= 1'b0;
        end else begin
            per_cnt_reg   <= per_cnt_next;
            per_first_reg <= per_first_next;
            period_reg    <= period_next;
            per_valid_reg <= per_valid_next;
        end
    end

    // Fault cause priority: shoot A, shoot B, short dead time, level jump
    always_comb begin
        cause = FLT_NONE;
        if (leg_shoot[0]) begin
            cause = FLT_SHOOT_A;
        end else if (leg_shoot[1]) begin
            cause = FLT_SHOOT_B;
        end else if (|leg_dt_short) begin
            cause = FLT_SHORT_DT;
        end else if (jump_reg) begin
            cause = FLT_JUMP;
        end
    end

    // Monitor FSM next state and sticky fault latch
    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        code_next  = code_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cause != FLT_NONE) begin
                    state_next = ST_FAULT;
                    fault_next = 1'b1;
                    code_next  = cause;
                end else if (!i_enable) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
                // Clearing is only honoured with the converter disabled
                if (i_clear && !i_enable) begin
                    state_next = ST_IDLE;
                    fault_next = 1'b0;
                    code_next  = FLT_NONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, fault and gate-enable registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg   <= ST_IDLE;
            fault_reg   <= 1'b0;
            code_reg    <= FLT_NONE;
            gate_ok_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fault_reg   <= fault_next;
            code_reg    <= code_next;
            gate_ok_reg <= i_enable & ~fault_next;
        end
    end

    assign o_level        = level_reg;
    assign o_level_valid  = level_valid_reg;
    assign o_dt_a         = leg_dt[0];
    assign o_dt_b         = leg_dt[1];
    assign o_dt_valid     = leg_dt_valid;
    assign o_period       = period_reg;
    assign o_period_valid = per_valid_reg;
    assign o_fault        = fault_reg;
    assign o_fault_code   = code_reg;
    assign o_gate_ok      = gate_ok_reg;

endmodule

// File: tb/tb_bridge_state_monitor.sv
// Bench for bridge_state_monitor: scoreboarded modulation sequence plus
// directed fault, clear and asynchronous-reset scenarios.
module tb_bridge_state_monitor;

    localparam int DT_W  = 10;
    localparam int PER_W = 16;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_enable;
    logic             i_clear;
    logic [3:0]       i_Q;
    logic [1:0]       o_level;
    logic             o_level_valid;
    logic [DT_W-1:0]  o_dt_a;
    logic [DT_W-1:0]  o_dt_b;
    logic [1:0]       o_dt_valid;
    logic [PER_W-1:0] o_period;
    logic             o_period_valid;
    logic             o_fault;
    logic [2:0]       o_fault_code;
    logic             o_gate_ok;

    bridge_state_monitor #(.DT_W(DT_W), .P_MIN_DT(10'd20), .PER_W(PER_W)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_clear        (i_clear),
        .i_Q            (i_Q),
        .o_level        (o_level),
        .o_level_valid  (o_level_valid),
        .o_dt_a         (o_dt_a),
        .o_dt_b         (o_dt_b),
        .o_dt_valid     (o_dt_valid),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_fault        (o_fault),
        .o_fault_code   (o_fault_code),
        .o_gate_ok      (o_gate_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_pos_cyc = 0;
    logic sb_on = 1'b0;
    logic [3:0] cur_q = 4'b0000;
    logic [1:0] prev_lvl = 2'b00;

    int q_dt_a [$];
    int q_dt_b [$];
    int q_per  [$];
    int q_lvl  [$];

    // Commanded sequence (Q4..Q1) and the level each pattern stands for
    logic [3:0] seq_q [4] = '{4'b0011, 4'b0110, 4'b0011, 4'b1001};
    logic [1:0] seq_l [4] = '{2'b00, 2'b11, 2'b00, 2'b01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One dead-time-inserted transition: changing leg off for dlen, then new pattern
    task automatic step(input logic [3:0] nq, input logic [1:0] lvl, input int dlen, input int hold);
        logic [3:0] chg;
        chg = cur_q ^ nq;
        i_Q = cur_q & nq;
        repeat (dlen) tick;
        if (sb_on) begin
            if ((chg & 4'b0101) != 4'b0000) q_dt_a.push_back(dlen);
            if ((chg & 4'b1010) != 4'b0000) q_dt_b.push_back(dlen);
            q_lvl.push_back(int'(lvl));
            if (lvl == 2'b01) begin
                q_per.push_back(cyc - last_pos_cyc);
                last_pos_cyc = cyc;
            end
        end
        i_Q   = nq;
        cur_q = nq;
        repeat (hold) tick;
    endtask

    // Enable from all-off, wait m cycles, then run ncycles 4-step modulation cycles
    task automatic run_seq(input int m, input int ncycles);
        i_enable = 1'b1;
        repeat (m) tick;
        q_dt_a.push_back(m);
        q_dt_b.push_back(m);
        q_lvl.push_back(1);
        last_pos_cyc = cyc;
        i_Q   = 4'b1001;
        cur_q = 4'b1001;
        repeat (75) tick;
        for (int c = 0; c < ncycles; c++) begin
            for (int s = 0; s < 4; s++) begin
                step(seq_q[s], seq_l[s], 25, 75);
            end
        end
        repeat (6) tick;
        check("sb_dt_a_drained", q_dt_a.size(), 0);
        check("sb_dt_b_drained", q_dt_b.size(), 0);
        check("sb_lvl_drained",  q_lvl.size(),  0);
        check("sb_per_drained",  q_per.size(),  0);
        check("seq_no_fault",    o_fault,       0);
        check("seq_gate_ok",     o_gate_ok,     1);
    endtask

    task automatic clear_fault;
        i_enable = 1'b0;
        tick;
        i_clear = 1'b1;
        tick;
        i_clear = 1'b0;
        check("clr_fault", o_fault, 0);
        check("clr_code",  o_fault_code, 0);
        i_enable = 1'b1;
        repeat (3) tick;
        check("reen_gate_ok", o_gate_ok, 1);
    endtask

    // Scoreboard monitor: pops an expectation for every DUT strobe or level change
    always @(negedge clk) begin
        if (!i_reset) begin
            prev_lvl = 2'b00;
        end else if (sb_on) begin
            if (o_dt_valid[0]) begin
                check("dt_a_expected", 32'(q_dt_a.size() > 0), 1);
                if (q_dt_a.size() > 0) check("dt_a", 32'(o_dt_a), q_dt_a.pop_front());
            end
            if (o_dt_valid[1]) begin
                check("dt_b_expected", 32'(q_dt_b.size() > 0), 1);
                if (q_dt_b.size() > 0) check("dt_b", 32'(o_dt_b), q_dt_b.pop_front());
            end
            if (o_period_valid) begin
                check("period_expected", 32'(q_per.size() > 0), 1);
                if (q_per.size() > 0) check("period", 32'(o_period), q_per.pop_front());
            end
            if (o_level_valid && (o_level != prev_lvl)) begin
                check("level_expected", 32'(q_lvl.size() > 0), 1);
                if (q_lvl.size() > 0) check("level", 32'(o_level), q_lvl.pop_front());
                prev_lvl = o_level;
            end
        end
    end

    initial begin
        i_reset  = 1'b0;
        i_enable = 1'b0;
        i_clear  = 1'b0;
        i_Q      = 4'b0000;
        repeat (3) tick;
        check("rst_level",   o_level,        0);
        check("rst_lvl_vld", o_level_valid,  0);
        check("rst_fault",   o_fault,        0);
        check("rst_code",    o_fault_code,   0);
        check("rst_gate_ok", o_gate_ok,      0);
        check("rst_period",  o_period,       0);
        i_reset = 1'b1;
        repeat (2) tick;

        // Modulation sequence, deadtime 25, 4 us cycle
        sb_on = 1'b1;
        run_seq(40, 2);
        check("period_400", o_period, 400);
        check("dt_a_25",    o_dt_a,   25);
        check("dt_b_25",    o_dt_b,   25);
        sb_on = 1'b0;

        // Shoot-through leg A for one cycle
        i_Q = 4'b1101;
        tick;
        i_Q = 4'b1001;
        tick;
        check("shoot_a_not_yet", o_fault, 0);
        tick;
        check("shoot_a_fault",   o_fault,      1);
        check("shoot_a_code",    o_fault_code, 1);
        check("shoot_a_gate",    o_gate_ok,    0);
        i_clear = 1'b1;
        tick;
        i_clear = 1'b0;
        tick;
        check("clr_enabled_kept", o_fault,      1);
        check("clr_enabled_code", o_fault_code, 1);
        clear_fault();

        // Shoot-through leg B
        i_Q = 4'b1011;
        tick;
        i_Q = 4'b1001;
        repeat (2) tick;
        check("shoot_b_fault", o_fault,      1);
        check("shoot_b_code",  o_fault_code, 2);
        clear_fault();

        // First short interval on B is ignored, the second one faults
        step(4'b0011, 2'b00, 5, 20);
        check("first_short_dt_b", o_dt_b,  5);
        check("first_short_ok",   o_fault, 0);
        step(4'b1001, 2'b01, 5, 0);
        repeat (2) tick;
        check("short_dt_b",     o_dt_b,     5);
        check("short_dt_vld",   o_dt_valid, 2);
        check("short_not_yet",  o_fault,    0);
        tick;
        check("short_fault",    o_fault,      1);
        check("short_code",     o_fault_code, 3);
        clear_fault();

        // +1 to -1 through 30 all-off cycles
        i_Q = 4'b0000;
        repeat (30) tick;
        i_Q = 4'b0110;
        repeat (2) tick;
        check("jump_not_yet", o_fault, 0);
        tick;
        check("jump_fault",   o_fault,      1);
        check("jump_code",    o_fault_code, 4);
        check("jump_dt_a",    o_dt_a,       30);

        // A later fault must not overwrite the first cause
        i_Q = 4'b1101;
        repeat (4) tick;
        check("code_sticky", o_fault_code, 4);

        // Asynchronous reset in the middle of a dead interval
        i_Q = 4'b0000;
        repeat (5) tick;
        #2;
        i_reset = 1'b0;
        #1;
        check("arst_fault",   o_fault,       0);
        check("arst_code",    o_fault_code,  0);
        check("arst_gate_ok", o_gate_ok,     0);
        check("arst_dt_a",    o_dt_a,        0);
        check("arst_period",  o_period,      0);
        check("arst_level",   o_level,       0);
        i_enable = 1'b0;
        cur_q    = 4'b0000;
        #2;
        i_reset = 1'b1;
        repeat (2) tick;
        sb_on = 1'b1;
        run_seq(40, 1);
        sb_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
